// File: rtl/sdram_test_pkg.sv
// Shared constants for the SDRAM memory tester: pattern selectors, FSM encodings
// and Galois LFSR feedback masks.
package sdram_test_pkg;

  localparam int PAT_ADDR  = 0;
  localparam int PAT_NADDR = 1;
  localparam int PAT_LFSR  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Right-shifting Galois feedback masks of maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/sdram_test_pattern_gen.sv
// Test-pattern source: address, inverted address, or a Galois LFSR that steps on
// advance_i and returns to the seed on reload_i.
module sdram_test_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int          ADDR_WIDTH = 22,
  parameter int          DATA_WIDTH = 16,
  parameter int          PATTERN    = 0,
  parameter logic [31:0] LFSR_SEED  = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  advance_i,
  input  logic                  reload_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(LFSR_SEED);

  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] addr_ext;

  assign addr_ext = DATA_WIDTH'(addr_i);

  always_comb begin
    lfsr_d = lfsr_q;
    if (reload_i) begin
      lfsr_d = SEED;
    end else if (advance_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    case (PATTERN)
      PAT_ADDR:  data_o = addr_ext;
      PAT_NADDR: data_o = ~addr_ext;
      default:   data_o = lfsr_q;
    endcase
  end

endmodule

// File: rtl/sdram_mem_tester.sv
// Avalon-MM traffic generator: writes a pattern over [START_ADDR..END_ADDR], reads it
// back with up to MAX_OUTSTANDING reads in flight and reports pass/fail plus the first error.
module sdram_mem_tester
  import sdram_test_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 22,
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR        = '1,
  parameter int                    PATTERN         = 0,
  parameter logic [31:0]           LFSR_SEED       = 32'd1,
  parameter int                    MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   av_address,
  output logic                    av_write,
  output logic                    av_read,
  output logic [DATA_WIDTH-1:0]   av_writedata,
  output logic [DATA_WIDTH/8-1:0] av_byteenable,
  input  logic                    av_waitrequest,
  input  logic [DATA_WIDTH-1:0]   av_readdata,
  input  logic                    av_readdatavalid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [DATA_WIDTH-1:0]   err_data,
  output logic [DATA_WIDTH-1:0]   err_expected
);

  // Pointers carry one spare bit so an all-ones END_ADDR can be passed without wrapping.
  localparam logic [ADDR_WIDTH:0] START_EXT = {1'b0, START_ADDR};
  localparam logic [ADDR_WIDTH:0] END_EXT   = {1'b0, END_ADDR};
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          MAX_OUT   = 4'(MAX_OUTSTANDING);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] chk_ptr_q, chk_ptr_d;
  logic [3:0]            outst_q, outst_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;

  logic [DATA_WIDTH-1:0] wr_data, chk_data;
  logic wr_acc, rd_acc, rsp_vld, mismatch, can_issue, start_go, wr_last;

  assign start_go  = (state_q == ST_IDLE) && start;
  assign wr_acc    = av_write && !av_waitrequest;
  assign rd_acc    = av_read && !av_waitrequest;
  assign wr_last   = wr_acc && (wr_ptr_q == END_EXT);
  // Responses only count while reads can be in flight; stray ones elsewhere are dropped.
  assign rsp_vld   = av_readdatavalid && (outst_q != 4'd0) &&
                     ((state_q == ST_READ) || (state_q == ST_DRAIN));
  assign mismatch  = rsp_vld && (av_readdata != chk_data);
  assign can_issue = !fail_q && (rd_ptr_q <= END_EXT) && (outst_q < MAX_OUT);

  assign av_write      = (state_q == ST_WRITE);
  assign av_read       = (state_q == ST_READ) && (hold_q || can_issue);
  assign av_address    = av_write ? wr_ptr_q[ADDR_WIDTH-1:0] :
                         av_read  ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;
  assign av_writedata  = av_write ? wr_data : '0;
  assign av_byteenable = (av_write || av_read) ? '1 : '0;

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_addr     = err_addr_q;
  assign err_data     = err_data_q;
  assign err_expected = err_exp_q;

  sdram_test_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .PATTERN(PATTERN), .LFSR_SEED(LFSR_SEED)
  ) u_issue_gen (
    .clk(clk), .reset(reset), .addr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .advance_i(wr_acc), .reload_i(start_go), .data_o(wr_data)
  );

  sdram_test_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .PATTERN(PATTERN), .LFSR_SEED(LFSR_SEED)
  ) u_check_gen (
    .clk(clk), .reset(reset), .addr_i(chk_ptr_q),
    .advance_i(rsp_vld), .reload_i(wr_last), .data_o(chk_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    chk_ptr_d  = chk_ptr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    err_exp_d  = err_exp_q;
    hold_d     = av_read && av_waitrequest;
    outst_d    = outst_q + {3'b000, rd_acc} - {3'b000, rsp_vld};

    if (rsp_vld) begin
      chk_ptr_d = chk_ptr_q + 1'b1;
      if (mismatch && !fail_q) begin
        fail_d     = 1'b1;
        err_addr_d = chk_ptr_q;
        err_data_d = av_readdata;
        err_exp_d  = chk_data;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_addr_d = '0;
          err_data_d = '0;
          err_exp_d  = '0;
          wr_ptr_d   = START_EXT;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_acc) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (wr_last) begin
            rd_ptr_d  = START_EXT;
            chk_ptr_d = START_ADDR;
            state_d   = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (rd_acc) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // A stalled read must complete its handshake before issuing stops.
        if (!(av_read && av_waitrequest) && ((rd_ptr_d > END_EXT) || fail_d)) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (outst_q == 4'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !fail_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      chk_ptr_q  <= '0;
      outst_q    <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      err_exp_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      chk_ptr_q  <= chk_ptr_d;
      outst_q    <= outst_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      err_exp_q  <= err_exp_d;
    end
  end

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Three tester instances (one per pattern, MAX_OUTSTANDING 2/3/4) share one Avalon RAM
// model with programmable read latency, random waitrequest and optional word corruption.
module tb_sdram_mem_tester;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  int   sel   = 0;

  logic          wait_r  = 1'b0;
  logic          rdv_r   = 1'b0;
  logic [DW-1:0] rdata_r = '0;

  logic [AW-1:0] av_address_a    [N];
  logic          av_write_a      [N];
  logic          av_read_a       [N];
  logic [DW-1:0] av_writedata_a  [N];
  logic [1:0]    av_byteenable_a [N];
  logic          busy_a          [N];
  logic          done_a          [N];
  logic          pass_a          [N];
  logic          fail_a          [N];
  logic [AW-1:0] err_addr_a      [N];
  logic [DW-1:0] err_data_a      [N];
  logic [DW-1:0] err_exp_a       [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    sdram_mem_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(4'h0), .END_ADDR(4'hF),
      .PATTERN(g), .LFSR_SEED(32'd1), .MAX_OUTSTANDING(g + 2)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start && (sel == g)),
      .av_address       (av_address_a[g]),
      .av_write         (av_write_a[g]),
      .av_read          (av_read_a[g]),
      .av_writedata     (av_writedata_a[g]),
      .av_byteenable    (av_byteenable_a[g]),
      .av_waitrequest   ((sel == g) ? wait_r : 1'b1),
      .av_readdata      (rdata_r),
      .av_readdatavalid (rdv_r && (sel == g)),
      .busy             (busy_a[g]),
      .done             (done_a[g]),
      .pass             (pass_a[g]),
      .fail             (fail_a[g]),
      .err_addr         (err_addr_a[g]),
      .err_data         (err_data_a[g]),
      .err_expected     (err_exp_a[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // RAM model state and observations
  typedef struct packed {
    int         due;
    logic [3:0] addr;
  } rsp_t;
  rsp_t          rsp_q[$];
  logic [DW-1:0] mem [16];
  int  lat = 2, wait_pct = 0;
  bit  corrupt = 0;
  int  ncyc = 0;
  int  n_wr, n_rd, n_rdv, n_done, stab_viol, be_viol, max_inflight, late_reads;
  int  bad_cyc, last_rdv_cyc, done_cyc;
  bit  prev_stall = 0, p_w = 0, p_r = 0;
  logic [AW-1:0] p_a;
  logic [DW-1:0] p_d;
  logic first_wr, first_busy;

  always @(negedge clk) begin
    rsp_t r;
    bit   req;
    ncyc++;
    if (reset) begin
      rsp_q.delete();
      rdv_r      = 1'b0;
      wait_r     = 1'b0;
      prev_stall = 0;
    end else begin
      rdv_r = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= ncyc) begin
        r       = rsp_q.pop_front();
        rdv_r   = 1'b1;
        rdata_r = (corrupt && r.addr == 4'd9) ? 16'hDEAD : mem[r.addr];
        if (corrupt && r.addr == 4'd9) bad_cyc = ncyc;
        n_rdv++;
        last_rdv_cyc = ncyc;
      end
      if (prev_stall && (av_write_a[sel] != p_w || av_read_a[sel] != p_r ||
                         av_address_a[sel] != p_a || (p_w && av_writedata_a[sel] != p_d)))
        stab_viol++;
      wait_r = ($urandom_range(99) < wait_pct);
      req    = av_write_a[sel] || av_read_a[sel];
      if (req && av_byteenable_a[sel] != 2'b11) be_viol++;
      if (av_write_a[sel] && !wait_r) begin
        mem[av_address_a[sel]] = av_writedata_a[sel];
        n_wr++;
      end
      if (av_read_a[sel] && !wait_r) begin
        r.due  = ncyc + lat;
        r.addr = av_address_a[sel];
        rsp_q.push_back(r);
        n_rd++;
        if (bad_cyc >= 0 && ncyc > bad_cyc) late_reads++;
      end
      if (n_rd - n_rdv > max_inflight) max_inflight = n_rd - n_rdv;
      if (done_a[sel]) begin
        n_done++;
        done_cyc = ncyc;
      end
      prev_stall = req && wait_r;
      p_w = av_write_a[sel];
      p_r = av_read_a[sel];
      p_a = av_address_a[sel];
      p_d = av_writedata_a[sel];
    end
  end

  // Expected word for address a: k-th write of a run from address 0 carries the k-th pattern value.
  function automatic logic [DW-1:0] ref_pat(input int pat, input int a);
    logic [DW-1:0] s;
    s = 16'h0001;
    if (pat == 0) return 16'(a);
    if (pat == 1) return ~16'(a);
    for (int k = 0; k < a; k++) s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    return s;
  endfunction

  function automatic int mem_errors(input int pat);
    int e;
    e = 0;
    for (int a = 0; a < 16; a++) if (mem[a] !== ref_pat(pat, a)) e++;
    return e;
  endfunction

  function automatic logic [63:0] out_vec(input int g);
    return {av_write_a[g], av_read_a[g], busy_a[g], done_a[g], pass_a[g], fail_a[g],
            av_address_a[g], av_writedata_a[g], av_byteenable_a[g],
            err_addr_a[g], err_data_a[g], err_exp_a[g]};
  endfunction

  task automatic clear_model(input int s, input int l, input int wp, input bit cor);
    sel = s; lat = l; wait_pct = wp; corrupt = cor;
    n_wr = 0; n_rd = 0; n_rdv = 0; n_done = 0; stab_viol = 0; be_viol = 0;
    max_inflight = 0; late_reads = 0; bad_cyc = -1; last_rdv_cyc = 0; done_cyc = 0;
    for (int a = 0; a < 16; a++) mem[a] = 16'h5A5A;
  endtask

  task automatic do_run(input int s, input int l, input int wp, input bit cor, input bit poke);
    bit seen;
    clear_model(s, l, wp, cor);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_wr   = av_write_a[s];
    first_busy = busy_a[s];
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      start = poke && (i == 4);
      if (done_a[s]) seen = 1;
    end
    start = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL run_timeout inst=%0d: done never seen, required a done pulse", s);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      n_cmp++;
      if (out_vec(g) !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d: got %h required 0", g, out_vec(g));
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      n_cmp++;
      if (out_vec(g) !== 64'd0) begin
        n_bad++;
        $display("FAIL idle_outputs inst=%0d: got %h required 0", g, out_vec(g));
      end
    end
  endtask

  task automatic test_addr_pattern();
    do_run(0, 2, 0, 0, 0);
    n_cmp++; if (first_wr !== 1'b1 || first_busy !== 1'b1) begin n_bad++;
      $display("FAIL first_write: write=%b busy=%b required 1 1", first_wr, first_busy); end
    n_cmp++; if (n_wr !== 16 || n_rd !== 16) begin n_bad++;
      $display("FAIL addr_counts: writes=%0d reads=%0d required 16 16", n_wr, n_rd); end
    n_cmp++; if (n_done !== 1) begin n_bad++;
      $display("FAIL addr_done_count: got %0d required 1", n_done); end
    n_cmp++; if (pass_a[0] !== 1'b1 || fail_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin n_bad++;
      $display("FAIL addr_status: pass=%b fail=%b busy=%b required 1 0 0", pass_a[0], fail_a[0], busy_a[0]); end
    n_cmp++; if (mem[5] !== 16'd5) begin n_bad++;
      $display("FAIL addr_word5: got %h required 0005", mem[5]); end
    n_cmp++; if (mem_errors(0) !== 0) begin n_bad++;
      $display("FAIL addr_mem: %0d words wrong, required 0", mem_errors(0)); end
    n_cmp++; if (done_cyc <= last_rdv_cyc) begin n_bad++;
      $display("FAIL addr_done_order: done cyc %0d last rdv cyc %0d, required done later", done_cyc, last_rdv_cyc); end
  endtask

  task automatic test_lfsr_random_wait();
    do_run(2, 3, 50, 0, 0);
    n_cmp++; if (pass_a[2] !== 1'b1 || fail_a[2] !== 1'b0) begin n_bad++;
      $display("FAIL lfsr_status: pass=%b fail=%b required 1 0", pass_a[2], fail_a[2]); end
    n_cmp++; if (mem_errors(2) !== 0) begin n_bad++;
      $display("FAIL lfsr_mem: %0d words wrong, required 0", mem_errors(2)); end
    n_cmp++; if (stab_viol !== 0) begin n_bad++;
      $display("FAIL lfsr_stable_under_wait: %0d changes, required 0", stab_viol); end
    n_cmp++; if (be_viol !== 0) begin n_bad++;
      $display("FAIL lfsr_byteenable: %0d bad cycles, required 0", be_viol); end
    n_cmp++; if (n_wr !== 16 || n_rd !== 16 || n_done !== 1) begin n_bad++;
      $display("FAIL lfsr_counts: wr=%0d rd=%0d done=%0d required 16 16 1", n_wr, n_rd, n_done); end
  endtask

  task automatic test_corrupt();
    do_run(1, 2, 0, 1, 0);
    n_cmp++; if (fail_a[1] !== 1'b1 || pass_a[1] !== 1'b0) begin n_bad++;
      $display("FAIL corrupt_status: pass=%b fail=%b required 0 1", pass_a[1], fail_a[1]); end
    n_cmp++; if (err_addr_a[1] !== 4'd9) begin n_bad++;
      $display("FAIL corrupt_err_addr: got %0d required 9", err_addr_a[1]); end
    n_cmp++; if (err_data_a[1] !== 16'hDEAD) begin n_bad++;
      $display("FAIL corrupt_err_data: got %h required DEAD", err_data_a[1]); end
    n_cmp++; if (err_exp_a[1] !== ref_pat(1, 9)) begin n_bad++;
      $display("FAIL corrupt_err_expected: got %h required %h", err_exp_a[1], ref_pat(1, 9)); end
    n_cmp++; if (late_reads !== 0) begin n_bad++;
      $display("FAIL corrupt_no_late_reads: %0d reads after mismatch, required 0", late_reads); end
    n_cmp++; if (n_rd >= 16 || n_rdv !== n_rd || n_done !== 1) begin n_bad++;
      $display("FAIL corrupt_drain: rd=%0d rdv=%0d done=%0d required rd<16 rdv=rd done=1", n_rd, n_rdv, n_done); end
  endtask

  task automatic test_outstanding();
    do_run(0, 6, 50, 0, 0);
    n_cmp++; if (max_inflight > 2) begin n_bad++;
      $display("FAIL outstanding_limit: peak %0d required <= 2", max_inflight); end
    n_cmp++; if (n_rd !== 16 || n_rdv !== 16 || pass_a[0] !== 1'b1) begin n_bad++;
      $display("FAIL outstanding_run: rd=%0d rdv=%0d pass=%b required 16 16 1", n_rd, n_rdv, pass_a[0]); end
  endtask

  task automatic test_busy_start_ignored();
    do_run(2, 1, 20, 0, 1);
    n_cmp++; if (n_wr !== 16 || n_rd !== 16 || n_done !== 1) begin n_bad++;
      $display("FAIL restart_ignored: wr=%0d rd=%0d done=%0d required 16 16 1", n_wr, n_rd, n_done); end
    n_cmp++; if (pass_a[2] !== 1'b1) begin n_bad++;
      $display("FAIL restart_pass: got %b required 1", pass_a[2]); end
  endtask

  task automatic test_reset_mid_read();
    clear_model(1, 6, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && n_rd < 3; i++) @(negedge clk);
    n_cmp++; if (n_rd < 3 || n_rd - n_rdv <= 0) begin n_bad++;
      $display("FAIL midread_setup: rd=%0d rdv=%0d required rd>=3 with responses pending", n_rd, n_rdv); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_vec(1) !== 64'd0) begin n_bad++;
      $display("FAIL midread_reset_outputs: got %h required 0", out_vec(1)); end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (out_vec(1) !== 64'd0) begin n_bad++;
      $display("FAIL midread_stays_idle: got %h required 0", out_vec(1)); end
  endtask

  task automatic test_run_after_reset();
    do_run(1, 2, 30, 0, 0);
    n_cmp++; if (pass_a[1] !== 1'b1 || fail_a[1] !== 1'b0) begin n_bad++;
      $display("FAIL rerun_status: pass=%b fail=%b required 1 0", pass_a[1], fail_a[1]); end
    n_cmp++; if ({err_addr_a[1], err_data_a[1], err_exp_a[1]} !== 36'd0) begin n_bad++;
      $display("FAIL rerun_err_clear: addr=%h data=%h exp=%h required 0", err_addr_a[1], err_data_a[1], err_exp_a[1]); end
    n_cmp++; if (mem_errors(1) !== 0 || n_done !== 1) begin n_bad++;
      $display("FAIL rerun_mem: %0d words wrong done=%0d required 0 1", mem_errors(1), n_done); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_addr_pattern();
    test_lfsr_random_wait();
    test_corrupt();
    test_outstanding();
    test_busy_start_ignored();
    test_reset_mid_read();
    test_run_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
